// File: rtl/ball_link_rx.sv
// ball_link_rx: receive side of the inter-board ball hand-off link.
// Deserialises the 6-byte UART frame, validates it and offers the decoded
// ball state to the game controller over a valid/ready handshake.
module ball_link_rx #(
    parameter int         CLKS_PER_BIT = 217,
    parameter int         TIMEOUT_CLKS = 8680,
    parameter int         Y_MAX        = 479,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       rx_serial,
    input  logic       ball_ready,
    output logic       ball_valid,
    output logic [9:0] ball_y,
    output logic [9:0] ball_y_vel,
    output logic [1:0] ball_type,
    output logic       peer_game_over,
    output logic       err_pulse,
    output logic       overrun_pulse,
    output logic [7:0] err_count
);

    localparam int BIT_CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TO_CW  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CW-1:0] FULL_LAST = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [TO_CW-1:0]  TO_LAST   = TO_CW'(TIMEOUT_CLKS - 1);
    localparam logic [9:0]        Y_LIMIT   = 10'(Y_MAX);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [2:0] {HUNT, GET_YHI, GET_YLO, GET_VEL, GET_INFO, GET_CSUM} frame_state_t;

    logic rx_meta, rx_sync;

    bit_state_t        bit_state, bit_next;
    logic [BIT_CW-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shreg, shreg_next;
    logic              byte_done, framing_err;

    frame_state_t     frame_state, frame_next;
    logic [TO_CW-1:0] to_cnt;
    logic [7:0]       y_hi, y_lo, vel, info, csum;
    logic             fields_ok, frame_ok, frame_bad;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_25MHZ) begin
        // NOTE: non-blocking (<=) so both stages sample pre-edge values; blocking
        // here would collapse the synchroniser into a single flop.
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    // Bit-level FSM state and datapath registers.
    always_ff @(posedge clk_25MHZ) begin
        if (!reset) begin
            bit_state <= B_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            bit_state <= bit_next;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            shreg     <= shreg_next;
        end
    end

    // Bit-level next state: mid-bit sampling; byte_done/framing_err fire in the stop-sample cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        bit_next     = bit_state;
        bit_cnt_next = bit_cnt + 1'b1;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        byte_done    = 1'b0;
        framing_err  = 1'b0;
        case (bit_state)
            B_IDLE: begin
                bit_cnt_next = '0;
                if (!rx_sync) bit_next = B_START;
            end
            B_START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    bit_next     = rx_sync ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (bit_cnt == FULL_LAST) begin
                    bit_cnt_next = '0;
                    shreg_next   = {rx_sync, shreg[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) bit_next = B_STOP;
                end
            end
            B_STOP: begin
                if (bit_cnt == FULL_LAST) begin
                    bit_cnt_next = '0;
                    bit_next     = B_IDLE;
                    byte_done    = rx_sync;
                    framing_err  = !rx_sync;
                end
            end
            default: bit_next = B_IDLE;
        endcase
    end

    // Byte-level FSM state register.
    always_ff @(posedge clk_25MHZ) begin
        if (!reset) frame_state <= HUNT;
        else        frame_state <= frame_next;
    end

    assign fields_ok = (y_hi[7:2] == 6'd0) && (info[7:3] == 5'd0) && ({y_hi[1:0], y_lo} <= Y_LIMIT);

    // Byte-level next state: frame sequencing, final validation, discard conditions.
    always_comb begin
        frame_next = frame_state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (framing_err && frame_state != HUNT) begin
            frame_bad  = 1'b1;
            frame_next = HUNT;
        end else if (byte_done) begin
            case (frame_state)
                HUNT:     if (shreg == SYNC_BYTE) frame_next = GET_YHI;
                GET_YHI:  frame_next = GET_YLO;
                GET_YLO:  frame_next = GET_VEL;
                GET_VEL:  frame_next = GET_INFO;
                GET_INFO: frame_next = GET_CSUM;
                GET_CSUM: begin
                    frame_next = HUNT;
                    frame_ok   = fields_ok && (shreg == csum);
                    frame_bad  = !(fields_ok && (shreg == csum));
                end
                default:  frame_next = HUNT;
            endcase
        end else if (frame_state != HUNT && to_cnt == TO_LAST) begin
            frame_bad  = 1'b1;
            frame_next = HUNT;
        end
    end

    // Field capture, running checksum and inter-byte timeout counter.
    always_ff @(posedge clk_25MHZ) begin
        if (!reset) begin
            to_cnt <= '0;
            y_hi   <= '0;
            y_lo   <= '0;
            vel    <= '0;
            info   <= '0;
            csum   <= '0;
        end else begin
            if (frame_state == HUNT || byte_done) to_cnt <= '0;
            else                                  to_cnt <= to_cnt + 1'b1;
            if (byte_done) begin
                case (frame_state)
                    HUNT:     csum <= '0;
                    GET_YHI:  begin y_hi <= shreg; csum <= csum ^ shreg; end
                    GET_YLO:  begin y_lo <= shreg; csum <= csum ^ shreg; end
                    GET_VEL:  begin vel  <= shreg; csum <= csum ^ shreg; end
                    GET_INFO: begin info <= shreg; csum <= csum ^ shreg; end
                    default:  ;
                endcase
            end
        end
    end

    // Output registers: load on accept, hold while stalled, drop valid after a transfer.
    always_ff @(posedge clk_25MHZ) begin
        if (!reset) begin
            ball_valid     <= 1'b0;
            ball_y         <= '0;
            ball_y_vel     <= '0;
            ball_type      <= '0;
            peer_game_over <= 1'b0;
            err_pulse      <= 1'b0;
            overrun_pulse  <= 1'b0;
            err_count      <= '0;
        end else begin
            err_pulse     <= frame_bad;
            overrun_pulse <= frame_ok && ball_valid && !ball_ready;
            if (frame_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (frame_ok) begin
                ball_valid     <= 1'b1;
                ball_y         <= {y_hi[1:0], y_lo};
                ball_y_vel     <= {{2{vel[7]}}, vel};
                ball_type      <= info[1:0];
                peer_game_over <= info[2];
            end else if (ball_valid && ball_ready) begin
                ball_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ball_link_rx.sv
// Self-checking bench for ball_link_rx: UART frame driver, negedge monitor
// and an arithmetic reference decoder of the frame rules.
module tb_ball_link_rx;

    localparam int CPB   = 16;
    localparam int TO    = 640;
    localparam int Y_MAX = 479;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] vel;
        logic [1:0] typ;
        logic       go;
    } ball_t;

    logic       clk_25MHZ = 1'b0;
    logic       reset, rx_serial, ball_ready;
    logic       ball_valid, peer_game_over, err_pulse, overrun_pulse;
    logic [9:0] ball_y, ball_y_vel;
    logic [1:0] ball_type;
    logic [7:0] err_count;

    int    n_checks = 0, n_errors = 0;
    int    cyc = 0, stop_cyc = 0, rise_cyc = -1;
    int    n_err_p = 0, n_ovr_p = 0, n_valid_cyc = 0;
    int    exp_errs = 0;
    logic  prev_v = 1'b0;
    ball_t xfer_q[$];
    ball_t exp_q[$];

    ball_link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .Y_MAX(Y_MAX), .SYNC_BYTE(8'hA5)) dut (
        .clk_25MHZ(clk_25MHZ), .reset(reset), .rx_serial(rx_serial), .ball_ready(ball_ready),
        .ball_valid(ball_valid), .ball_y(ball_y), .ball_y_vel(ball_y_vel), .ball_type(ball_type),
        .peer_game_over(peer_game_over), .err_pulse(err_pulse), .overrun_pulse(overrun_pulse),
        .err_count(err_count)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    always @(posedge clk_25MHZ) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle, counts pulses and records every handshake transfer.
    always @(negedge clk_25MHZ) begin
        if (err_pulse) n_err_p <= n_err_p + 1;
        if (overrun_pulse) n_ovr_p <= n_ovr_p + 1;
        if (ball_valid) n_valid_cyc <= n_valid_cyc + 1;
        if (ball_valid && !prev_v) rise_cyc <= cyc;
        prev_v <= ball_valid;
        if (ball_valid && ball_ready) xfer_q.push_back({ball_y, ball_y_vel, ball_type, peer_game_over});
    end

    initial begin
        #8000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // Reference decoder straight from the frame rules.
    function automatic bit model_decode(input logic [47:0] f, output ball_t b);
        int s, hi, lo, vl, inf, cs, y, v;
        s   = int'(f[47:40]);
        hi  = int'(f[39:32]);
        lo  = int'(f[31:24]);
        vl  = int'(f[23:16]);
        inf = int'(f[15:8]);
        cs  = int'(f[7:0]);
        y   = (hi % 4) * 256 + lo;
        v   = (vl >= 128) ? vl - 256 : vl;
        b.y   = 10'(y);
        b.vel = 10'(v);
        b.typ = 2'(inf % 4);
        b.go  = 1'((inf / 4) % 2);
        return (s == 165) && (cs == (hi ^ lo ^ vl ^ inf)) && (hi < 4) && (inf < 8) && (y <= Y_MAX);
    endfunction

    function automatic logic [47:0] make_frame(input int y, input int v, input int typ, input int go);
        int hi, lo, vl, inf, cs;
        hi  = y / 256;
        lo  = y % 256;
        vl  = v & 255;
        inf = go * 4 + typ;
        cs  = hi ^ lo ^ vl ^ inf;
        return {8'hA5, 8'(hi), 8'(lo), 8'(vl), 8'(inf), 8'(cs)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25MHZ);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            tick(CPB);
        end
        rx_serial = stop_bit;
        stop_cyc  = cyc;
        tick(CPB);
        rx_serial = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b1);
    endtask

    task automatic test_reset();
        tick(4);
        n_checks++;
        if ({ball_valid, ball_y, ball_y_vel, ball_type, peer_game_over, err_pulse, overrun_pulse, err_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {ball_valid, ball_y, ball_y_vel, ball_type, peer_game_over, err_pulse, overrun_pulse, err_count});
        end
        reset = 1'b1;
        tick(4 * CPB);
        n_checks++;
        if (ball_valid !== 1'b0 || n_err_p != 0) begin
            n_errors++;
            $display("FAIL reset_idle: valid=%b errs=%0d, expected 0/0", ball_valid, n_err_p);
        end
    endtask

    task automatic test_clean();
        int    base_vc;
        ball_t exp_b = {10'd300, 10'h3FD, 2'd2, 1'b0};
        ball_ready = 1'b1;
        xfer_q.delete();
        base_vc = n_valid_cyc;
        send_frame(48'hA5_01_2C_FD_02_D2);
        tick(CPB);
        n_checks++;
        if (xfer_q.size() != 1) begin
            n_errors++;
            $display("FAIL clean_count: got %0d transfers, expected 1", xfer_q.size());
        end else begin
            n_checks++;
            if (xfer_q[0] !== exp_b) begin
                n_errors++;
                $display("FAIL clean_data: got %h, expected %h", xfer_q[0], exp_b);
            end
        end
        // Two synchroniser edges + one edge to leave idle + half a bit to the sample edge, which loads.
        n_checks++;
        if (rise_cyc - stop_cyc != CPB / 2 + 3) begin
            n_errors++;
            $display("FAIL clean_latency: got %0d cycles, expected %0d", rise_cyc - stop_cyc, CPB / 2 + 3);
        end
        n_checks++;
        if (n_valid_cyc - base_vc != 1) begin
            n_errors++;
            $display("FAIL clean_valid_width: got %0d cycles, expected 1", n_valid_cyc - base_vc);
        end
        n_checks++;
        if (err_count !== 8'(exp_errs)) begin
            n_errors++;
            $display("FAIL clean_err_count: got %0d, expected %0d", err_count, exp_errs);
        end
    endtask

    task automatic test_bad_csum();
        int base_err;
        xfer_q.delete();
        base_err = n_err_p;
        send_frame(48'hA5_01_2C_FD_02_D3);
        exp_errs++;
        tick(CPB);
        n_checks++;
        if (xfer_q.size() != 0 || n_err_p - base_err != 1 || err_count !== 8'(exp_errs)) begin
            n_errors++;
            $display("FAIL bad_csum: xfers=%0d pulses=%0d count=%0d, expected 0/1/%0d",
                     xfer_q.size(), n_err_p - base_err, err_count, exp_errs);
        end
        send_frame(48'hA5_01_2C_FD_02_D2);
        tick(CPB);
        n_checks++;
        if (xfer_q.size() != 1 || ball_y !== 10'd300) begin
            n_errors++;
            $display("FAIL csum_recover: xfers=%0d y=%0d, expected 1/300", xfer_q.size(), ball_y);
        end
    endtask

    task automatic test_bad_stop();
        int base_err;
        xfer_q.delete();
        base_err = n_err_p;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2C, 1'b0);
        exp_errs++;
        tick(3 * CPB);
        n_checks++;
        if (xfer_q.size() != 0 || n_err_p - base_err != 1 || err_count !== 8'(exp_errs)) begin
            n_errors++;
            $display("FAIL bad_stop: xfers=%0d pulses=%0d count=%0d, expected 0/1/%0d",
                     xfer_q.size(), n_err_p - base_err, err_count, exp_errs);
        end
    endtask

    task automatic test_glitch();
        int    base_err;
        ball_t b;
        logic [47:0] f;
        xfer_q.delete();
        base_err = n_err_p;
        rx_serial = 1'b0;
        tick(CPB / 2 - 3);
        rx_serial = 1'b1;
        tick(2 * CPB);
        f = make_frame(int'($urandom_range(0, Y_MAX)), int'($urandom_range(0, 255)) - 128,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        void'(model_decode(f, b));
        send_frame(f);
        tick(CPB);
        n_checks++;
        if (n_err_p != base_err || xfer_q.size() != 1) begin
            n_errors++;
            $display("FAIL glitch: pulses=%0d xfers=%0d, expected 0/1", n_err_p - base_err, xfer_q.size());
        end else begin
            n_checks++;
            if (xfer_q[0] !== b) begin
                n_errors++;
                $display("FAIL glitch_data: got %h, expected %h", xfer_q[0], b);
            end
        end
    endtask

    task automatic test_timeout();
        int    base_err;
        ball_t b;
        logic [47:0] f;
        xfer_q.delete();
        base_err = n_err_p;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(TO - 3 * CPB);
        n_checks++;
        if (n_err_p != base_err) begin
            n_errors++;
            $display("FAIL timeout_early: got %0d pulses, expected 0", n_err_p - base_err);
        end
        tick(6 * CPB);
        exp_errs++;
        n_checks++;
        if (n_err_p - base_err != 1 || err_count !== 8'(exp_errs)) begin
            n_errors++;
            $display("FAIL timeout_err: pulses=%0d count=%0d, expected 1/%0d", n_err_p - base_err, err_count, exp_errs);
        end
        f = make_frame(479, 127, 3, 1);
        void'(model_decode(f, b));
        send_frame(f);
        tick(CPB);
        n_checks++;
        if (xfer_q.size() != 1 || xfer_q[0] !== b) begin
            n_errors++;
            $display("FAIL timeout_recover: xfers=%0d last=%h, expected 1/%h", xfer_q.size(),
                     {ball_y, ball_y_vel, ball_type, peer_game_over}, b);
        end
    endtask

    task automatic test_overrun();
        int    base_ovr;
        ball_t b2;
        logic [47:0] f2;
        xfer_q.delete();
        base_ovr = n_ovr_p;
        ball_ready = 1'b0;
        f2 = make_frame(200, -3, 1, 0);
        void'(model_decode(f2, b2));
        send_frame(make_frame(100, 5, 0, 1));
        send_frame(f2);
        tick(CPB);
        n_checks++;
        if (ball_valid !== 1'b1 || ball_y !== 10'd200) begin
            n_errors++;
            $display("FAIL overrun_hold: valid=%b y=%0d, expected 1/200", ball_valid, ball_y);
        end
        n_checks++;
        if (n_ovr_p - base_ovr != 1 || xfer_q.size() != 0) begin
            n_errors++;
            $display("FAIL overrun_pulse: pulses=%0d xfers=%0d, expected 1/0", n_ovr_p - base_ovr, xfer_q.size());
        end
        ball_ready = 1'b1;
        tick(1);
        n_checks++;
        if (ball_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_drop: valid=%b, expected 0", ball_valid);
        end
        tick(CPB);
        n_checks++;
        if (xfer_q.size() != 1 || xfer_q[0] !== b2) begin
            n_errors++;
            $display("FAIL overrun_xfer: xfers=%0d, expected 1 of %h", xfer_q.size(), b2);
        end
    endtask

    task automatic test_random();
        logic [47:0] f;
        ball_t b;
        int    kind, nbad, base_err;
        nbad = 0;
        ball_ready = 1'b1;
        xfer_q.delete();
        exp_q.delete();
        base_err = n_err_p;
        for (int i = 0; i < 10; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 3)
                f = make_frame(int'($urandom_range(Y_MAX + 1, 1023)), int'($urandom_range(0, 255)) - 128,
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            else
                f = make_frame(int'($urandom_range(0, Y_MAX)), int'($urandom_range(0, 255)) - 128,
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            if (kind == 2) f[7:0] = f[7:0] ^ 8'(1 << $urandom_range(0, 7));
            if (model_decode(f, b)) exp_q.push_back(b);
            else nbad++;
            send_frame(f);
            tick(int'($urandom_range(0, CPB)));
        end
        exp_errs += nbad;
        tick(CPB);
        n_checks++;
        if (n_err_p - base_err != nbad || err_count !== 8'(exp_errs)) begin
            n_errors++;
            $display("FAIL random_errs: pulses=%0d count=%0d, expected %0d/%0d",
                     n_err_p - base_err, err_count, nbad, exp_errs);
        end
        n_checks++;
        if (xfer_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL random_count: got %0d transfers, expected %0d", xfer_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (xfer_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL random_data[%0d]: got %h, expected %h", i, xfer_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int    base_err;
        ball_t b;
        logic [47:0] f;
        logic [7:0]  v = 8'hFD;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2C, 1'b1);
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_serial = v[i];
            tick(CPB);
        end
        reset = 1'b0;
        rx_serial = 1'b1;
        tick(3);
        exp_errs = 0;
        n_checks++;
        if ({ball_valid, ball_y, ball_y_vel, ball_type, peer_game_over, err_pulse, overrun_pulse, err_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %h, expected 0",
                     {ball_valid, ball_y, ball_y_vel, ball_type, peer_game_over, err_pulse, overrun_pulse, err_count});
        end
        reset = 1'b1;
        base_err = n_err_p;
        tick(TO + 2 * CPB);
        n_checks++;
        if (n_err_p != base_err || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_mid_err: pulses=%0d count=%0d, expected 0/0", n_err_p - base_err, err_count);
        end
        xfer_q.delete();
        f = make_frame(int'($urandom_range(0, Y_MAX)), int'($urandom_range(0, 255)) - 128,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        void'(model_decode(f, b));
        send_frame(f);
        tick(CPB);
        n_checks++;
        if (xfer_q.size() != 1 || xfer_q[0] !== b || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_mid_recover: xfers=%0d count=%0d, expected 1 of %h / 0",
                     xfer_q.size(), err_count, b);
        end
    endtask

    initial begin
        reset      = 1'b0;
        rx_serial  = 1'b1;
        ball_ready = 1'b0;
        test_reset();
        test_clean();
        test_bad_csum();
        test_bad_stop();
        test_glitch();
        test_timeout();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
